// File: rtl/pdp8_panel_pkg.sv
// Shared constants and state encoding for the PDP-8 front-panel engine.
// Combinational definitions only; no timing or flow control.
package pdp8_panel_pkg;

  localparam int AW = 7;
  localparam int WW = 12;
  localparam logic [3:0] BA_LAST = 4'(WW - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DHI  = 3'd1,
    DLO  = 3'd2,
    EXAM = 3'd3,
    VRD  = 3'd4
  } state_t;

endpackage

// File: rtl/pdp8_bitseq.sv
// Bit-address counter shared by deposit, examine and verify sequences.
// Updates one cycle after clear/step; never stalls, clear wins over step.
module pdp8_bitseq
  import pdp8_panel_pkg::*;
#(
  parameter int WW = pdp8_panel_pkg::WW
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  output logic [3:0] ba,
  output logic       last
);

  localparam logic [3:0] LAST_BA = 4'(WW - 1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ba <= 4'd0;
    end else if (clear) begin
      ba <= 4'd0;
    end else if (step) begin
      ba <= ba + 4'd1;
    end
  end

  assign last = (ba == LAST_BA);

endmodule

// File: rtl/pdp8_panel.sv
// Front-panel load/deposit/examine engine; deposit 2*WW cycles, examine WW cycles.
// Commands accepted only when idle, ignored while busy. PANEL_VERIFY_EN adds readback verify.
module pdp8_panel
  import pdp8_panel_pkg::*;
#(
  parameter int AW = pdp8_panel_pkg::AW,
  parameter int WW = pdp8_panel_pkg::WW
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [WW-1:0] sr,
  input  logic          load_addr,
  input  logic          dep,
  input  logic          exam,
  input  logic          membus,
  output logic [AW-1:0] ma,
  output logic [3:0]    ba,
  output logic          mb,
  output logic          write,
  output logic [WW-1:0] mbuf,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state, state_n;
  logic [AW-1:0] ma_n;
  logic          mb_n, write_n, busy_n, done_n;
  logic [WW-1:0] data, data_n, mbuf_n;
  logic          bs_clear, bs_step, bs_last;
  logic [3:0]    ba_nx;
`ifdef PANEL_VERIFY_EN
  logic          err_n;
`endif

  pdp8_bitseq #(.WW(WW)) u_bitseq (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (bs_clear),
    .step   (bs_step),
    .ba     (ba),
    .last   (bs_last)
  );

  always_comb begin
    state_n  = state;
    ma_n     = ma;
    mb_n     = mb;
    write_n  = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    data_n   = data;
    mbuf_n   = mbuf;
    bs_clear = 1'b0;
    bs_step  = 1'b0;
    ba_nx    = ba + 4'd1;
`ifdef PANEL_VERIFY_EN
    err_n    = err;
`endif
    case (state)
      IDLE: begin
        if (load_addr) begin
          ma_n = sr[AW-1:0];
        end else if (dep) begin
          data_n   = sr;
          mb_n     = sr[0];
          write_n  = 1'b1;
          busy_n   = 1'b1;
          bs_clear = 1'b1;
          state_n  = DHI;
`ifdef PANEL_VERIFY_EN
          err_n    = 1'b0;
`endif
        end else if (exam) begin
          busy_n   = 1'b1;
          bs_clear = 1'b1;
          state_n  = EXAM;
        end
      end
      // write drops here with ba/mb held, so the memory commits on a stable bit
      DHI: begin
        state_n = DLO;
      end
      DLO: begin
        if (bs_last) begin
          bs_clear = 1'b1;
`ifdef PANEL_VERIFY_EN
          state_n  = VRD;
`else
          state_n  = IDLE;
          busy_n   = 1'b0;
          ma_n     = ma + 1'b1;
          done_n   = 1'b1;
`endif
        end else begin
          bs_step = 1'b1;
          mb_n    = data[ba_nx];
          write_n = 1'b1;
          state_n = DHI;
        end
      end
      EXAM: begin
        mbuf_n[ba] = membus;
        if (bs_last) begin
          bs_clear = 1'b1;
          state_n  = IDLE;
          busy_n   = 1'b0;
          ma_n     = ma + 1'b1;
          done_n   = 1'b1;
        end else begin
          bs_step = 1'b1;
        end
      end
`ifdef PANEL_VERIFY_EN
      // readback of the word just written; ma still points at it
      VRD: begin
        mbuf_n[ba] = membus;
        if (membus != data[ba]) err_n = 1'b1;
        if (bs_last) begin
          bs_clear = 1'b1;
          state_n  = IDLE;
          busy_n   = 1'b0;
          ma_n     = ma + 1'b1;
          done_n   = 1'b1;
        end else begin
          bs_step = 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ma    <= '0;
      mb    <= 1'b0;
      write <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
      mbuf  <= '0;
    end else begin
      state <= state_n;
      ma    <= ma_n;
      mb    <= mb_n;
      write <= write_n;
      busy  <= busy_n;
      done  <= done_n;
      data  <= data_n;
      mbuf  <= mbuf_n;
    end
  end

`ifdef PANEL_VERIFY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= err_n;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pdp8_panel.sv
// Bench for pdp8_panel: bit-serial memory model plus done-driven scoreboard.
module tb_pdp8_panel;

  localparam int AW = 7;
  localparam int WW = 12;
`ifdef PANEL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int DEP_CYC = VERIFY ? 36 : 24;

  logic          sysclk, reset;
  logic [WW-1:0] sr;
  logic          load_addr, dep, exam, membus;
  logic [AW-1:0] ma;
  logic [3:0]    ba;
  logic          mb, write, busy, done, err;
  logic [WW-1:0] mbuf;

  pdp8_panel #(.AW(AW), .WW(WW)) dut (
    .sysclk(sysclk), .reset(reset), .sr(sr), .load_addr(load_addr), .dep(dep),
    .exam(exam), .membus(membus), .ma(ma), .ba(ba), .mb(mb), .write(write),
    .mbuf(mbuf), .busy(busy), .done(done), .err(err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // memory: address/data captured while write is high, committed on its fall
  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] lat_a = '0;
  logic [3:0]    lat_b = '0;
  logic          lat_d = 1'b0;
  logic          stuck3 = 1'b0;
  logic [WW-1:0] rd_word;

  always @(ma or ba or mb or write)
    if (write) begin lat_a = ma; lat_b = ba; lat_d = mb; end
  always @(negedge write)
    mem[lat_a][lat_b] = (stuck3 && lat_b == 4'd3) ? 1'b0 : lat_d;
  assign rd_word = mem[ma];
  assign membus  = rd_word[ba];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", nm, act, expv);
    end
  endtask

  typedef struct {
    bit            is_dep;
    logic [AW-1:0] addr;
    logic [WW-1:0] word;
    logic [AW-1:0] ma_after;
    int            cycles;
    bit            chk_mbuf;
    logic [WW-1:0] mbuf_exp;
    bit            err_exp;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  function automatic exp_t mk(bit d, logic [AW-1:0] a, logic [WW-1:0] w, logic [AW-1:0] m,
                              int c, bit cm, logic [WW-1:0] mbx, bit ex);
    exp_t r;
    r.is_dep = d; r.addr = a; r.word = w; r.ma_after = m;
    r.cycles = c; r.chk_mbuf = cm; r.mbuf_exp = mbx; r.err_exp = ex;
    return r;
  endfunction

  int         busy_cnt = 0;
  int         wr_cnt = 0;
  logic [11:0] ba_seen = '0;
  logic       wr_prev = 1'b0;

  always @(negedge sysclk) begin
    if (reset) begin
      busy_cnt = 0; wr_cnt = 0; ba_seen = '0; wr_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (write) begin
        ba_seen[ba] = 1'b1;
        if (!wr_prev) wr_cnt++;
      end
      wr_prev = write;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_ma", 32'(ma), 32'(e.ma_after));
          chk("busy_cycles", busy_cnt, e.cycles);
          chk("err_flag", 32'(err), 32'(e.err_exp));
          if (e.chk_mbuf) chk("mbuf", 32'(mbuf), 32'(e.mbuf_exp));
          if (e.is_dep) begin
            chk("mem_word", 32'(mem[e.addr]), 32'(e.word));
            chk("write_pulses", wr_cnt, 12);
            chk("write_ba_set", 32'(ba_seen), 32'o7777);
          end
        end
        busy_cnt = 0; wr_cnt = 0; ba_seen = '0;
      end
    end
  end

  task automatic cmd(input logic l, input logic d, input logic x, input logic [WW-1:0] s);
    @(posedge sysclk);
    #1 sr = s; load_addr = l; dep = d; exam = x;
    @(posedge sysclk);
    #1 load_addr = 1'b0; dep = 1'b0; exam = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sysclk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sr = '0; load_addr = 1'b0; dep = 1'b0; exam = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    #12;
    chk("rst_ma", 32'(ma), 0);     chk("rst_ba", 32'(ba), 0);
    chk("rst_mb", 32'(mb), 0);     chk("rst_write", 32'(write), 0);
    chk("rst_mbuf", 32'(mbuf), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0);
    mem[7'o110] = 12'o0007;
    @(negedge sysclk) reset = 1'b0;

    cmd(1, 0, 0, 12'o0100);
    chk("load_ma", 32'(ma), 32'o100);
    chk("load_busy", 32'(busy), 0);
    sbq.push_back(mk(1, 7'o100, 12'o7300, 7'o101, DEP_CYC, VERIFY, 12'o7300, 0));
    cmd(0, 1, 0, 12'o7300);
    wait_done("dep_7300");

    cmd(1, 0, 0, 12'o0110);
    sbq.push_back(mk(0, 7'o110, 12'o0007, 7'o111, 12, 1, 12'o0007, 0));
    cmd(0, 0, 1, 12'o0000);
    wait_done("exam_0110");
    @(negedge sysclk);
    chk("done_one_cycle", 32'(done), 0);

    cmd(1, 1, 0, 12'o0050);
    chk("prio_ma", 32'(ma), 32'o050);
    repeat (3) @(negedge sysclk);
    chk("prio_busy", 32'(busy), 0);
    chk("prio_no_write", 32'(mem[7'o050]), 0);

    sbq.push_back(mk(1, 7'o050, 12'o4321, 7'o051, DEP_CYC, VERIFY, 12'o4321, 0));
    cmd(0, 1, 0, 12'o4321);
    repeat (4) @(posedge sysclk);
    cmd(0, 0, 1, 12'o0000);
    wait_done("dep_exam_ignored");
    @(negedge sysclk);
    chk("exam_not_queued", 32'(busy), 0);

    cmd(1, 0, 0, 12'o0177);
    sbq.push_back(mk(1, 7'o177, 12'o1234, 7'o000, DEP_CYC, VERIFY, 12'o1234, 0));
    cmd(0, 1, 0, 12'o1234);
    wait_done("dep_wrap");

    cmd(1, 0, 0, 12'o0177);
    sbq.push_back(mk(0, 7'o177, 12'o1234, 7'o000, 12, 1, 12'o1234, 0));
    cmd(0, 0, 1, 12'o0000);
    wait_done("exam_wrap");

    cmd(1, 0, 0, 12'o0060);
    cmd(0, 1, 0, 12'o7777);
    repeat (10) @(posedge sysclk);
    #1;
    chk("midrst_ba", 32'(ba), 5);
    chk("midrst_write", 32'(write), 1);
    reset = 1'b1;
    #1;
    chk("midrst_ma", 32'(ma), 0);     chk("midrst_ba0", 32'(ba), 0);
    chk("midrst_mb", 32'(mb), 0);     chk("midrst_wr0", 32'(write), 0);
    chk("midrst_busy", 32'(busy), 0); chk("midrst_mbuf", 32'(mbuf), 0);
    chk("midrst_word", 32'(mem[7'o060]), 32'o0077);
    @(negedge sysclk) reset = 1'b0;

`ifdef PANEL_VERIFY_EN
    cmd(1, 0, 0, 12'o0070);
    sbq.push_back(mk(1, 7'o070, 12'o2106, 7'o071, 36, 1, 12'o2106, 0));
    cmd(0, 1, 0, 12'o2106);
    wait_done("vrf_good");

    stuck3 = 1'b1;
    cmd(1, 0, 0, 12'o0071);
    sbq.push_back(mk(1, 7'o071, 12'o0000, 7'o072, 36, 1, 12'o0000, 1));
    cmd(0, 1, 0, 12'o0010);
    wait_done("vrf_stuck");
    repeat (5) @(negedge sysclk);
    chk("err_sticky", 32'(err), 1);

    stuck3 = 1'b0;
    cmd(1, 0, 0, 12'o0072);
    chk("err_hold_load", 32'(err), 1);
    sbq.push_back(mk(1, 7'o072, 12'o0001, 7'o073, 36, 1, 12'o0001, 0));
    cmd(0, 1, 0, 12'o0001);
    chk("err_clear_dep", 32'(err), 0);
    wait_done("vrf_clear");
`endif

    repeat (3) @(negedge sysclk);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdp8_panel.md
Name: pdp8_panel

Overview:
- Front-panel load/deposit/examine engine for the bit-serial PDP-8 system.
- Sits directly upstream of the bit-serial memory and drives its ma/ba/mb/write port while the CPU is halted.
- Deposits a 12-bit switch-register word into memory one bit at a time, and examines a word by serially reading the memory's membus bit.
- The system-level mux hands the memory port to this block whenever busy=1.

Parameters:
AW, 7, memory word-address width (ma)
WW, 12, word width; bits addressed by ba = 0..WW-1

Ports:
sysclk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
sr  input  WW  switch register (address or data source)
load_addr  input  1  single-cycle pulse: ma <= sr[AW-1:0]
dep  input  1  single-cycle pulse: deposit sr at ma, then ma++
exam  input  1  single-cycle pulse: read word at ma into mbuf, then ma++
membus  input  1  serial read bit from memory (combinational in ma, ba)
ma  output  AW  memory word address
ba  output  4  memory bit address
mb  output  1  serial write data bit
write  output  1  write strobe; memory commits bit ba on the falling edge
mbuf  output  WW  last examined word
busy  output  1  high while a deposit/examine sequence owns the memory port
done  output  1  one-cycle pulse after a deposit/examine completes
err  output  1  verify mismatch flag (only with PANEL_VERIFY_EN; else tied 0)

Behaviour:
- Reset is asynchronous. ma=0, ba=0, mb=0, write=0, mbuf=0, busy=0, done=0, err=0, state=IDLE.
- Reset mid-deposit drops write. The resulting falling edge commits the current bit ba with its correct mb value, so no corruption beyond a partial word.
- States: IDLE, DHI, DLO, EXAM (plus VRD with the optional feature).
- Commands are sampled only in IDLE. Priority is load_addr > dep > exam. Commands arriving while busy=1 are ignored, not queued.
- load_addr: on the accepting edge, ma <= sr[AW-1:0]. Stays in IDLE with busy=0 and done=0.
- dep accept edge:
  - latch sr into an internal data register;
  - ba=0, mb=data[0], write=1, busy=1; go to DHI.
- DHI -> DLO: write=0, with ba and mb held. The falling edge commits the bit.
- DLO:
  - If ba==WW-1: go to IDLE; write=0, busy=0, ma <= ma+1 (wraps mod 2^AW), done=1 for one cycle.
  - Else: ba++, mb=data[ba+1], write=1; go to DHI.
- ba and mb never change on the same edge that write falls.
- Deposit occupies exactly 2*WW = 24 cycles of busy.
- exam accept edge: ba=0, busy=1; go to EXAM.
- EXAM, each edge:
  - mbuf[ba] <= membus;
  - if ba==WW-1: go to IDLE, ba=0, busy=0, ma++ (wrap), done=1;
  - else ba++.
- Examine occupies WW = 12 cycles of busy.
- mbuf bits not yet sampled keep their old value until the sequence completes. Outside busy, mbuf is stable.
- write is never high outside DHI.
- ba returns to 0 in IDLE after every sequence.
- mb holds its last value in IDLE.

Optional Feature:
- Macro PANEL_VERIFY_EN.
- When defined: after the last DLO, the block does not return to IDLE. It enters VRD, an examine-style readback of the same address (ma not yet incremented).
  - VRD adds 12 cycles, for 36 busy cycles per deposit.
  - err is set (sticky) if any readback bit differs from the latched data. err is cleared only by reset or the next dep accept.
  - mbuf receives the readback word. ma increments after VRD, and done pulses then.
- When undefined: there is no VRD state, err is constant 0, and deposit timing is as above.

Decomposition:
- Shared package: AW and WW constants, state encoding (IDLE/DHI/DLO/EXAM/VRD), and BA_LAST = WW-1.
- One natural sub-module: pdp8_bitseq, the bit counter driving ba.
  - Inputs: clear and step.
  - Output: last flag.
  - Reused for deposit, examine and verify.

Test Plan:
- Load and deposit: sr=0100, pulse load_addr; sr=7300, pulse dep.
  - Expect busy=24 cycles, then done.
  - Memory word 0100 reads 7300 and ma=0101.
  - write shows 12 high pulses, one per ba value 0..11.
- Examine: preload memory 0110=0007; load_addr 0110; pulse exam.
  - Expect busy=12 cycles, then mbuf=0007, ma=0111, done one cycle.
- Priority and ignore:
  - load_addr and dep asserted together -> only the address loads, busy stays 0.
  - exam pulsed mid-deposit -> ignored; deposit result is unchanged.
- Wrap: load_addr 0177, deposit 1234 -> word 0177=1234 and ma=0000.
- Reset mid-deposit at ba=5 (deposit 7777 over 0000):
  - Outputs return to reset values immediately.
  - Word holds bits 0..5 set (0077), and the other bits are unchanged.
- PANEL_VERIFY_EN:
  - Deposit 2106 -> busy=36 cycles, mbuf=2106, err=0.
  - Force the memory model to stick bit 3 at 0, then deposit 0010 -> err=1, which persists until the next dep.
